alu_sequencer: RTL

Multi-cycle operation sequencer that drives the 32-bit combinational ALU (opcode 0 or, 1 and, 2 add, 3 sub, 4 negate, 5 shr, 6 shl, 7 ror, 8 rol, 9 shra) from the initiator side. It latches operands and opcode on a start request, presents them to the ALU, captures the ALU result into a Z register, and signals completion. The ALU's shift and rotate ops move A by one bit per pass, so the sequencer implements multi-bit shifts by feeding the result back into A once per cycle for a count taken from B[4:0].

---
 rtl/alu_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle operation sequencer for the external 32-bit ALU.
// Multi-bit shifts and rotates are built by feeding alu_c back into A once per cycle.
//
// state   | meaning
// IDLE    | waiting for start; all registers hold
// EXEC    | single-pass op 0-4 on the ALU; alu_c captured into Z
// SHIFT   | one-bit pass per cycle while cnt != 0; A copied into Z when cnt hits 0
// DONE    | one-cycle done pulse (err if opcode was invalid); start ignored
module alu_sequencer (
  input  logic        i_clock,
  input  logic        i_clear,
  input  logic        i_start,
  input  logic [4:0]  i_opcode,
  input  logic [31:0] i_ra_data,
  input  logic [31:0] i_rb_data,
  input  logic [31:0] i_alu_c,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [4:0]  o_alu_op,
  output logic [31:0] o_z_out,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [4:0] OP_LAST_EXEC  = 5'd4;
  localparam logic [4:0] OP_LAST_SHIFT = 5'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_op;
  logic [4:0]  r_cnt;
  logic [31:0] r_z;
  logic        r_err;
  logic        r_busy;
  logic        r_done;

  logic        w_op_exec;
  logic        w_op_shift;

  assign w_op_exec  = (i_opcode <= OP_LAST_EXEC);
  assign w_op_shift = (i_opcode > OP_LAST_EXEC) && (i_opcode <= OP_LAST_SHIFT);

  // busy/done/err are registered alongside the state so they align with it exactly
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_z     <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_op_exec) begin
              r_a     <= i_ra_data;
              r_b     <= i_rb_data;
              r_op    <= i_opcode;
              r_busy  <= 1'b1;
              r_state <= S_EXEC;
            end else if (w_op_shift) begin
              r_a     <= i_ra_data;
              r_b     <= i_rb_data;
              r_op    <= i_opcode;
              r_cnt   <= i_rb_data[4:0];
              r_busy  <= 1'b1;
              r_state <= S_SHIFT;
            end else begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          r_z     <= i_alu_c;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_SHIFT: begin
          if (r_cnt != 5'd0) begin
            r_a   <= i_alu_c;
            r_cnt <= r_cnt - 5'd1;
          end else begin
            r_z     <= r_a;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_alu_a  = r_a;
  assign o_alu_b  = r_b;
  assign o_alu_op = r_op;
  assign o_z_out  = r_z;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_err    = r_err;

endmodule
